// File: rtl/buzzer_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : buzzer_pwm_ctrl
// Brief    : Self-running C-major scale player driving a piezo buzzer.
// Revision : 1.0 - initial release
// ============================================================================
module buzzer_pwm_ctrl #(
    parameter int CLK_HZ  = 10_000_000,
    parameter int NOTE_MS = 250,
    parameter int GAP_MS  = 20,
    parameter int REST_MS = 500,
    parameter int SCALE   = 1
) (
    input  logic clk,
    input  logic resetn,
    output logic buzzer
);

    function automatic int clamp1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int hp(input int f);
        return clamp1(CLK_HZ / (2 * f * SCALE));
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int c_KHZ      = CLK_HZ / 1000;
    localparam int c_NOTE_CYC = clamp1(c_KHZ * NOTE_MS / SCALE);
    localparam int c_GAP_CYC  = clamp1(c_KHZ * GAP_MS / SCALE);
    localparam int c_REST_CYC = clamp1(c_KHZ * REST_MS / SCALE);
    localparam int c_CYC_MAX  = max3(c_NOTE_CYC, c_GAP_CYC, c_REST_CYC);
    localparam int c_DW       = $clog2(c_CYC_MAX + 1);
    // The lowest note has the longest half period, so it sizes the tone counter.
    localparam int c_HW       = $clog2(hp(262) + 1);

    localparam logic [c_DW-1:0] c_NOTE_LAST = c_DW'(c_NOTE_CYC - 1);
    localparam logic [c_DW-1:0] c_GAP_LAST  = c_DW'(c_GAP_CYC - 1);
    localparam logic [c_DW-1:0] c_REST_LAST = c_DW'(c_REST_CYC - 1);

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_GAP  = 2'd1,
        S_REST = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_idx,   w_idx_nxt;
    logic [c_DW-1:0] r_dur,   w_dur_nxt;
    logic [c_HW-1:0] r_hp,    w_hp_nxt;
    logic            r_buzz,  w_buzz_nxt;
    logic [c_HW-1:0] w_hp_last;

    always_comb begin
        case (r_idx)
            3'd0:    w_hp_last = c_HW'(hp(262) - 1);
            3'd1:    w_hp_last = c_HW'(hp(294) - 1);
            3'd2:    w_hp_last = c_HW'(hp(330) - 1);
            3'd3:    w_hp_last = c_HW'(hp(349) - 1);
            3'd4:    w_hp_last = c_HW'(hp(392) - 1);
            3'd5:    w_hp_last = c_HW'(hp(440) - 1);
            3'd6:    w_hp_last = c_HW'(hp(494) - 1);
            default: w_hp_last = c_HW'(hp(523) - 1);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_dur_nxt   = r_dur + 1'b1;
        w_hp_nxt    = '0;
        w_buzz_nxt  = 1'b0;
        case (r_state)
            S_PLAY: begin
                if (r_hp == w_hp_last) begin
                    w_buzz_nxt = ~r_buzz;
                end else begin
                    w_hp_nxt   = r_hp + 1'b1;
                    w_buzz_nxt = r_buzz;
                end
                // Note end overrides a coincident toggle: the gap starts silent.
                if (r_dur == c_NOTE_LAST) begin
                    w_state_nxt = S_GAP;
                    w_dur_nxt   = '0;
                    w_hp_nxt    = '0;
                    w_buzz_nxt  = 1'b0;
                end
            end
            S_GAP: begin
                if (r_dur == c_GAP_LAST) begin
                    w_dur_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_REST;
                    end else begin
                        w_state_nxt = S_PLAY;
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
            S_REST: begin
                if (r_dur == c_REST_LAST) begin
                    w_dur_nxt   = '0;
                    w_state_nxt = S_PLAY;
                    w_idx_nxt   = 3'd0;
                end
            end
            default: begin
                w_state_nxt = S_PLAY;
                w_idx_nxt   = 3'd0;
                w_dur_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_PLAY;
            r_idx   <= 3'd0;
            r_dur   <= '0;
            r_hp    <= '0;
            r_buzz  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_dur   <= w_dur_nxt;
            r_hp    <= w_hp_nxt;
            r_buzz  <= w_buzz_nxt;
        end
    end

    assign buzzer = r_buzz;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_pwm_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_buzzer_pwm_ctrl
// Brief    : Randomised reset-point bench against an arithmetic melody model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buzzer_pwm_ctrl;

    localparam int c_CLK_HZ = 10_000_000;
    localparam int c_SCALE  = 1000;

    logic clk;
    logic resetn;
    logic buzz_s;
    logic buzz_d;

    int n_checks;
    int n_fail;
    int t;

    int c_n;
    int c_g;
    int c_r;
    int c_loop;
    int hpv [8];
    int freq [8];

    buzzer_pwm_ctrl #(.SCALE(c_SCALE)) u_dut_s (
        .clk    (clk),
        .resetn (resetn),
        .buzzer (buzz_s)
    );

    buzzer_pwm_ctrl u_dut_d (
        .clk    (clk),
        .resetn (resetn),
        .buzzer (buzz_d)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d actual=%0h expected=%0h", tag, t, act, exp);
        end
    endtask

    // Expected buzzer level t clocks after reset release, from the melody rules.
    function automatic logic model_buzz(input int tt);
        int pos, n, off;
        pos = tt % c_loop;
        if (pos >= 8 * (c_n + c_g)) return 1'b0;
        n   = pos / (c_n + c_g);
        off = pos % (c_n + c_g);
        if (off >= c_n) return 1'b0;
        return ((off / hpv[n]) % 2) == 1;
    endfunction

    function automatic string region(input int tt);
        int pos;
        pos = tt % c_loop;
        if (pos >= 8 * (c_n + c_g)) return "rest";
        if ((pos % (c_n + c_g)) >= c_n) return "gap";
        return "play";
    endfunction

    task automatic step(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            t++;
            chk(region(t), {31'd0, buzz_s}, {31'd0, model_buzz(t)});
        end
    endtask

    task automatic sync_reset_release();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        t = 0;
        chk("rst_state", {31'd0, buzz_s}, 32'd0);
    endtask

    task automatic async_reset_and_restart();
        #7;
        resetn = 1'b0;
        #1;
        chk("async_rst", {31'd0, buzz_s}, 32'd0);
        @(negedge clk);
        chk("rst_hold", {31'd0, buzz_s}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        t = 0;
        step(100);
    endtask

    initial begin
        int t3;
        clk      = 1'b0;
        resetn   = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        t        = 0;
        freq     = '{262, 294, 330, 349, 392, 440, 494, 523};
        c_n      = (c_CLK_HZ / 1000) * 250 / c_SCALE;
        c_g      = (c_CLK_HZ / 1000) * 20 / c_SCALE;
        c_r      = (c_CLK_HZ / 1000) * 500 / c_SCALE;
        c_loop   = 8 * (c_n + c_g) + c_r;
        for (int i = 0; i < 8; i++) hpv[i] = c_CLK_HZ / (2 * freq[i] * c_SCALE);

        sync_reset_release();
        chk("dflt_rst", {31'd0, buzz_d}, 32'd0);
        for (int i = 0; i < 200; i++) begin
            step(1);
            chk("dflt_quiet", {31'd0, buzz_d}, 32'd0);
            chk("dflt_known", {31'd0, $isunknown(buzz_d)}, 32'd0);
        end
        chk("first_rise_level", {31'd0, model_buzz(hpv[0])}, 32'd1);

        // Full loop plus the start of the second pass.
        step(c_loop + 3000 - t);

        // Reset while note 3 is in a high phase.
        sync_reset_release();
        t3 = 3 * (c_n + c_g) + hpv[3] * (2 * $urandom_range(0, 50) + 1)
             + $urandom_range(0, hpv[3] - 1);
        step(t3);
        chk("n3_high", {31'd0, buzz_s}, 32'd1);
        async_reset_and_restart();

        for (int k = 0; k < 3; k++) begin
            sync_reset_release();
            step($urandom_range(100, 12000));
            async_reset_and_restart();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout t=%0d actual=running expected=finished", t);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/buzzer_pwm_ctrl.md
Name: buzzer_pwm_ctrl

Overview:
- Self-running melody generator that drives a piezo buzzer with a square wave.
- Plays a fixed 8-note ascending C-major scale (C4..C5), with a short silent gap after each note and a longer rest after the last note, then loops forever.
- Has no control inputs. Sits at board top level, fed by the 10 MHz system clock.

Parameters:
- CLK_HZ, 10_000_000, input clock frequency in Hz.
- NOTE_MS, 250, audible duration of each note in ms.
- GAP_MS, 20, silence after each note in ms.
- REST_MS, 500, extra silence after note 7, before looping to note 0, in ms.
- SCALE, 1, divides every derived cycle count to shorten simulation; 1 in hardware.

Ports:
- clk  input  1  system clock, rising-edge active.
- resetn  input  1  asynchronous active-low reset.
- buzzer  output  1  square-wave tone output, registered.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, resetn).
- Derived constants, all integer truncating division, each clamped to a minimum of 1:
  - NOTE_CYC = (CLK_HZ/1000)*NOTE_MS/SCALE
  - GAP_CYC = (CLK_HZ/1000)*GAP_MS/SCALE
  - REST_CYC = (CLK_HZ/1000)*REST_MS/SCALE
  - HP[n] = CLK_HZ/(2*F[n]*SCALE)
- Note ROM F[0..7] in Hz: 262, 294, 330, 349, 392, 440, 494, 523.
- HP at defaults: 19083, 17006, 15151, 14326, 12755, 11363, 10121, 9560.
- Counter widths are sized from the maximum counts. No counter may overflow.
- Reset (resetn=0, asynchronous): buzzer=0, state=PLAY, note index=0, all counters=0. Reset is held while low.
- First edge after release: PLAY starts for note 0.
- States: PLAY -> GAP -> (index<7 ? PLAY at index+1 : REST) ; REST -> PLAY at index 0.
- PLAY:
  - Duration counter runs 0..NOTE_CYC-1.
  - Half-period counter runs 0..HP[idx]-1. On the cycle it equals HP[idx]-1, buzzer toggles and the half-period counter clears.
  - When the duration counter reaches NOTE_CYC-1, go to GAP.
- PLAY entry: half-period counter=0 and buzzer=0. The first rising edge of buzzer therefore occurs HP[idx] cycles after PLAY entry.
  - Tone frequency = CLK_HZ/(2*HP[idx]).
  - Duty cycle is 50%.
- GAP: buzzer forced 0 for exactly GAP_CYC cycles.
- REST: buzzer forced 0 for exactly REST_CYC cycles.
- Full loop length = 8*(NOTE_CYC+GAP_CYC)+REST_CYC cycles. Index wraps 7 -> 0 via REST only.
- Note-end boundary: if the note ends on the same cycle as a toggle, the GAP transition wins and buzzer is 0 on the next cycle.
- Reset mid-note: returns immediately to the reset state. The melody restarts from note 0 after release.
- Buzzer is a flop output with no combinational path from state.

Test Plan:
- Defaults, 10 MHz clk, resetn low for 2 cycles then high; run 200 cycles -> buzzer stays 0 throughout (HP[0]=19083 not reached) and has no X after reset.
- SCALE=1000 (HP[0]=19, NOTE_CYC=2500, GAP_CYC=200, REST_CYC=5000), after reset:
  - buzzer first rises 19 cycles after PLAY entry.
  - It toggles every 19 cycles, giving a period of 38 cycles.
- SCALE=1000, note sequencing -> high-phase lengths per note are 19, 17, 15, 14, 12, 11, 10, 9 cycles. Each note lasts 2500 cycles, followed by exactly 200 cycles of buzzer=0.
- SCALE=1000, loop -> after note 7's gap, buzzer is 0 for 5000 cycles. Note 0 restarts at cycle 8*2700+5000=26600 after release.
- SCALE=1000, assert resetn low mid-note 3 while buzzer=1 -> buzzer goes to 0 asynchronously before the next clk edge. After release, the next high phase is 19 cycles (note 0).
- SCALE=1000, check the boundary where note end coincides with a toggle -> buzzer=0 on the first GAP cycle. No glitch pulse.
